// File: rtl/ex_div_if.sv
// Handshake and data bundle between the execute stage and the iterative divider.
// The master side (execute stage) launches and annuls; the slave side returns the result.
interface ex_div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU, one quotient bit per cycle,
// with a divide-by-zero fast path and an annul abort for flushed instructions.
//
// state  | meaning
// FREE   | idle, outputs cleared, waiting for start_i
// BYZERO | divisor was zero, result forced to 0 next edge
// ON     | 32 restoring steps, then sign fix-up and result capture
// END    | result valid, held while start_i stays high
module ex_div (
    input logic clk,
    input logic rst,
    ex_div_if.slave bus
);
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] work;      // {partial remainder, quotient being shifted in}
    logic [31:0] divisor;
    logic        quo_neg;
    logic        rem_neg;

    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        abs1 = bus.opdata1_i;
        abs2 = bus.opdata2_i;
        if (bus.signed_div_i && bus.opdata1_i[31])
            abs1 = ~bus.opdata1_i + 32'd1;
        if (bus.signed_div_i && bus.opdata2_i[31])
            abs2 = ~bus.opdata2_i + 32'd1;
        // trial remainder is the current remainder with the next dividend bit appended;
        // it is always below twice the divisor, so 33 bits hold the difference
        diff    = work[63:31] - {1'b0, divisor};
        quo_fix = quo_neg ? (~work[31:0] + 32'd1) : work[31:0];
        rem_fix = rem_neg ? (~work[63:32] + 32'd1) : work[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FREE;
            cnt          <= 6'd0;
            work         <= 64'd0;
            divisor      <= 32'd0;
            quo_neg      <= 1'b0;
            rem_neg      <= 1'b0;
            bus.result_o <= 64'd0;
            bus.ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= 64'd0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == 32'd0) begin
                            state <= BYZERO;
                        end else begin
                            state   <= ON;
                            cnt     <= 6'd0;
                            work    <= {32'd0, abs1};
                            divisor <= abs2;
                            quo_neg <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                            rem_neg <= bus.signed_div_i & bus.opdata1_i[31];
                        end
                    end
                end
                BYZERO: begin
                    state        <= END;
                    work         <= 64'd0;
                    bus.result_o <= 64'd0;
                    bus.ready_o  <= 1'b1;
                end
                ON: begin
                    if (bus.annul_i) begin
                        state        <= FREE;
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= 64'd0;
                    end else if (cnt != 6'd32) begin
                        if (diff[32])
                            work <= {work[62:0], 1'b0};
                        else
                            work <= {diff[31:0], work[30:0], 1'b1};
                        cnt <= cnt + 6'd1;
                    end else begin
                        bus.result_o <= {rem_fix, quo_fix};
                        bus.ready_o  <= 1'b1;
                        state        <= END;
                    end
                end
                END: begin
                    if (!bus.start_i) begin
                        state        <= FREE;
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= 64'd0;
                    end
                end
                default: begin
                    state        <= FREE;
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= 64'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: a cycle-level reference (arithmetic result plus
// a countdown to the ready edge) is compared against the DUT on every negedge.
module tb_ex_div;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_div_if bus();

    ex_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    logic        m_ready  = 1'b0;
    logic [63:0] m_result = 64'd0;
    logic [63:0] m_pend   = 64'd0;
    int          m_wait   = 0;
    bit          m_zero   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural result: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready  = 1'b0;
            m_result = 64'd0;
            m_wait   = 0;
        end else if (m_ready) begin
            if (!bus.start_i) begin
                m_ready  = 1'b0;
                m_result = 64'd0;
            end
        end else if (m_wait > 0) begin
            if (bus.annul_i && !m_zero) begin
                m_wait = 0;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_ready  = 1'b1;
                    m_result = m_pend;
                end
            end
        end else if (bus.start_i && !bus.annul_i) begin
            m_pend = ref_div(bus.signed_div_i, bus.opdata1_i, bus.opdata2_i);
            m_zero = (bus.opdata2_i == 32'd0);
            m_wait = m_zero ? 1 : 33;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_ready", {63'd0, bus.ready_o}, {63'd0, m_ready});
            chk("cyc_result", bus.result_o, m_result);
        end
    end

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic ann);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = ann;
        @(posedge clk);
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat, input int hold, input string name);
        int lat;
        launch(sgn, a, b, 1'b0);
        #2;
        bus.opdata1_i    = 32'h0BAD_F00D;
        bus.opdata2_i    = 32'h0000_0007;
        bus.signed_div_i = ~sgn;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.ready_o) break;
        end
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_res"}, bus.result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({name, "_hold"}, {bus.ready_o, bus.result_o[62:0]}, {1'b1, exp[62:0]});
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_drop"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
    endtask

    initial begin
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 2, "u100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 1, "s_m7_2");
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1, "s_7_m2");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1, "s_min_m1");
        run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33, 1, "u_big");
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 1, "u_max_1");
        run_div(1'b0, 32'd5, 32'd9, 64'h00000005_00000000, 33, 1, "u5_9");
        run_div(1'b0, 32'h12345678, 32'd0, 64'd0, 1, 5, "div0");
        run_div(1'b1, 32'h87654321, 32'd0, 64'd0, 1, 1, "sdiv0");

        // annul at cnt=10
        launch(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("annul10_ready", {63'd0, bus.ready_o}, 64'd0);
        run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1, "u9_3");

        // annul on the same edge as the final step
        launch(1'b0, 32'd50, 32'd5, 1'b0);
        repeat (32) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("annul32_ready", {63'd0, bus.ready_o}, 64'd0);

        // annul on the launch edge
        launch(1'b0, 32'd50, 32'd5, 1'b1);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("annul_e0_ready", {63'd0, bus.ready_o}, 64'd0);

        // async reset mid-ON
        launch(1'b1, 32'hFFFFFF00, 32'd3, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_on", {bus.result_o[62:0], bus.ready_o}, 64'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_on_after", {63'd0, bus.ready_o}, 64'd0);

        // async reset while a result is held
        launch(1'b0, 32'd1000, 32'd10, 1'b0);
        repeat (34) @(posedge clk);
        #1;
        chk("pre_rst_res", bus.result_o, 64'h00000000_00000064);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_end", {bus.result_o[62:0], bus.ready_o}, 64'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_end_after", {63'd0, bus.ready_o}, 64'd0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
